// File: rtl/m31_dot_product_scheduler_if.sv
// Requester-side bundle of m31_dot_product_scheduler: per-requester job inputs, grant/index
// back to the requesters, and the tagged dot-product result.
interface m31_dot_product_scheduler_if #(
  parameter int WORD_WIDTH = 31,
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ-1:0][WORD_WIDTH-1:0] a_in;
  logic [NUM_REQ-1:0][WORD_WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]                 gnt;
  logic [IDX_WIDTH-1:0]               elem_idx;
  logic                               busy;
  logic [WORD_WIDTH-1:0]              result;
  logic [ID_WIDTH-1:0]                result_id;
  logic                               result_valid;

  modport master (
    output req, a_in, b_in,
    input  gnt, elem_idx, busy, result, result_id, result_valid
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, elem_idx, busy, result, result_id, result_valid
  );
endinterface

// File: rtl/m31_dot_product_scheduler.sv
// Round-robin scheduler sharing one pipelined M31 multiply-accumulate between requesters.
// Optional macro M31_DOT_SCHED_ABORT_EN: granted req falling during ISSUE/DRAIN aborts the job.
module m31_dot_product_scheduler #(
  parameter int WORD_WIDTH  = 31,
  parameter int VECTOR_SIZE = 16,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2,
  parameter int ID_WIDTH    = $clog2(NUM_REQ),
  parameter int IDX_WIDTH   = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1
) (
  input logic clk,
  input logic reset,
  m31_dot_product_scheduler_if.slave bus
);

  localparam int PROD_W = 2 * WORD_WIDTH;
  localparam int SUM_W  = 2 * WORD_WIDTH + 1;
  localparam int DCNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [WORD_WIDTH-1:0] MODULUS    = {WORD_WIDTH{1'b1}};
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX   = IDX_WIDTH'(VECTOR_SIZE - 1);
  localparam logic [DCNT_W-1:0]     LAST_DRAIN = DCNT_W'(MUL_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ID_WIDTH-1:0]    id_q, id_d;
  logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic [WORD_WIDTH-1:0]  acc_q, acc_d;
  logic [MUL_LATENCY-1:0] vld_q;
  logic [PROD_W-1:0]      prod_q [MUL_LATENCY];

  logic                   found;
  logic [ID_WIDTH-1:0]    pick;
  logic                   abort;
  logic [WORD_WIDTH-1:0]  mulA, mulB;
  logic [PROD_W-1:0]      mulProd;

  // Two folds of 2^31 = 1 bring any sum below 2*MODULUS, so one conditional subtract is canonical.
  function automatic logic [WORD_WIDTH-1:0] modReduce(input logic [SUM_W-1:0] x);
    logic [WORD_WIDTH+2:0] fold1;
    logic [WORD_WIDTH:0]   fold2;
    fold1 = (WORD_WIDTH+3)'(x[SUM_W-1:WORD_WIDTH]) + (WORD_WIDTH+3)'(x[WORD_WIDTH-1:0]);
    fold2 = (WORD_WIDTH+1)'(fold1[WORD_WIDTH-1:0]) + (WORD_WIDTH+1)'(fold1[WORD_WIDTH+2:WORD_WIDTH]);
    if (fold2 >= {1'b0, MODULUS}) begin
      fold2 = fold2 - {1'b0, MODULUS};
    end
    return fold2[WORD_WIDTH-1:0];
  endfunction

  always_comb begin
    int cand;
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          id_d    = pick;
          ptr_d   = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
          idx_d   = '0;
          dcnt_d  = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == LAST_DRAIN) begin
          state_d = DONE;
          dcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef M31_DOT_SCHED_ABORT_EN
    if ((state_q == ISSUE || state_q == DRAIN) && !bus.req[id_q]) begin
      abort   = 1'b1;
      state_d = IDLE;
      idx_d   = '0;
      dcnt_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      dcnt_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      acc_q   <= acc_d;
    end
  end

  assign mulA    = bus.a_in[id_q];
  assign mulB    = bus.b_in[id_q];
  assign mulProd = PROD_W'(mulA) * PROD_W'(mulB);

  // Products travel with a valid bit so the accumulator only sees issued elements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) prod_q[s] <= '0;
    end else if (abort) begin
      vld_q <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) prod_q[s] <= '0;
    end else begin
      vld_q[0]  <= (state_q == ISSUE);
      prod_q[0] <= mulProd;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        vld_q[s]  <= vld_q[s-1];
        prod_q[s] <= prod_q[s-1];
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (state_q == IDLE || abort) begin
      acc_d = '0;
    end else if (vld_q[MUL_LATENCY-1]) begin
      acc_d = modReduce(SUM_W'(acc_q) + SUM_W'(prod_q[MUL_LATENCY-1]));
    end
  end

  assign bus.gnt          = (state_q != IDLE) ? (NUM_REQ'(1) << id_q) : '0;
  assign bus.elem_idx     = idx_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = (state_q == DONE) ? acc_q : '0;
  assign bus.result_id    = (state_q == DONE) ? id_q : '0;

endmodule
